// File: rtl/multi_ch_bus_watchdog_if.sv
// Bus-side signal bundle for multi_ch_bus_watchdog.
// Protocol-check outputs exist only when WDT_PROTOCOL_CHECK_EN is defined.
interface multi_ch_bus_watchdog_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_CNT_W = 8
);
  logic [NUM_CH-1:0]    start;
  logic [NUM_CH-1:0]    complete;
  logic [CNT_W-1:0]     timeout_cfg;
  logic [NUM_CH-1:0]    err_clear;
  logic [NUM_CH-1:0]    busy;
  logic [NUM_CH-1:0]    timeout_pulse;
  logic [NUM_CH-1:0]    timeout_sticky;
  logic                 any_timeout;
  logic [ERR_CNT_W-1:0] err_count;
`ifdef WDT_PROTOCOL_CHECK_EN
  logic [NUM_CH-1:0]    late_complete;
  logic [NUM_CH-1:0]    spurious_complete;
`endif

  // Master: the bus side driving transactions and reading status.
  modport master (
    output start,
    output complete,
    output timeout_cfg,
    output err_clear,
    input  busy,
    input  timeout_pulse,
    input  timeout_sticky,
    input  any_timeout,
`ifdef WDT_PROTOCOL_CHECK_EN
    input  late_complete,
    input  spurious_complete,
`endif
    input  err_count
  );

  // Slave: the watchdog itself.
  modport slave (
    input  start,
    input  complete,
    input  timeout_cfg,
    input  err_clear,
    output busy,
    output timeout_pulse,
    output timeout_sticky,
    output any_timeout,
`ifdef WDT_PROTOCOL_CHECK_EN
    output late_complete,
    output spurious_complete,
`endif
    output err_count
  );
endinterface

// File: rtl/multi_ch_bus_watchdog.sv
// Multi-channel start/complete watchdog with per-channel budget, sticky errors and a
// saturating shared error count. Define WDT_PROTOCOL_CHECK_EN for late/spurious pulses.
module multi_ch_bus_watchdog #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  multi_ch_bus_watchdog_if.slave bus
);

  localparam int unsigned PopW = $clog2(NUM_CH + 1);
  localparam int unsigned SumW = ((ERR_CNT_W > PopW) ? ERR_CNT_W : PopW) + 1;
  localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

  typedef enum logic [1:0] {StIdle, StActive, StExpired} state_e;

  state_e               state_q  [NUM_CH];
  logic [CNT_W-1:0]     cnt_q    [NUM_CH];
  logic [CNT_W-1:0]     budget_q [NUM_CH];
  logic [NUM_CH-1:0]    pulse_q;
  logic [NUM_CH-1:0]    sticky_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic [NUM_CH-1:0]    expire;
  logic [NUM_CH-1:0]    busy;
  logic [PopW-1:0]      n_expire;
  logic [SumW-1:0]      err_sum;
`ifdef WDT_PROTOCOL_CHECK_EN
  logic [NUM_CH-1:0]    late_q;
  logic [NUM_CH-1:0]    spurious_q;
`endif

  // Expiry is the last budgeted cycle passing with neither start nor complete.
  always_comb begin
    expire   = '0;
    busy     = '0;
    n_expire = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      busy[i]   = (state_q[i] == StActive);
      expire[i] = (state_q[i] == StActive) && !bus.start[i] && !bus.complete[i] &&
                  (cnt_q[i] == budget_q[i] - CNT_W'(1));
      n_expire  = n_expire + PopW'(expire[i]);
    end
  end

  always_comb begin
    err_sum = SumW'(err_count_q) + SumW'(n_expire);
    if (err_sum > SumW'(ErrMax)) begin
      err_count_d = ErrMax;
    end else begin
      err_count_d = err_sum[ERR_CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        cnt_q[i]    <= '0;
        budget_q[i] <= CNT_W'(1);
      end
      pulse_q     <= '0;
      sticky_q    <= '0;
      err_count_q <= '0;
`ifdef WDT_PROTOCOL_CHECK_EN
      late_q      <= '0;
      spurious_q  <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        pulse_q[i]  <= expire[i];
        // Set wins over a coincident clear.
        sticky_q[i] <= expire[i] | (sticky_q[i] & ~bus.err_clear[i]);
`ifdef WDT_PROTOCOL_CHECK_EN
        late_q[i]     <= (state_q[i] == StExpired) && bus.complete[i] && !bus.start[i];
        spurious_q[i] <= (state_q[i] == StIdle) && bus.complete[i] && !bus.start[i];
`endif
        if (bus.start[i]) begin
          state_q[i]  <= StActive;
          cnt_q[i]    <= '0;
          budget_q[i] <= (bus.timeout_cfg == '0) ? CNT_W'(1) : bus.timeout_cfg;
        end else begin
          unique case (state_q[i])
            StActive: begin
              if (bus.complete[i]) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
              end else if (expire[i]) begin
                state_q[i] <= StExpired;
                cnt_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + CNT_W'(1);
              end
            end
            StExpired: begin
              if (bus.complete[i]) begin
                state_q[i] <= StIdle;
              end
            end
            StIdle: begin
            end
            default: state_q[i] <= StIdle;
          endcase
        end
      end
      err_count_q <= err_count_d;
    end
  end

  assign bus.busy           = busy;
  assign bus.timeout_pulse  = pulse_q;
  assign bus.timeout_sticky = sticky_q;
  assign bus.any_timeout    = |sticky_q;
  assign bus.err_count      = err_count_q;
`ifdef WDT_PROTOCOL_CHECK_EN
  assign bus.late_complete     = late_q;
  assign bus.spurious_complete = spurious_q;
`endif

endmodule
